chargen_sink: RTL and testbench
===============================

// Module: chargen_sink
// PURPOSE
//  Receiving end of the chargen byte stream: drives ready_n, accepts bytes on
//  port when valid_n is low, and checks they follow the cyclic sequence
//  FIRSTCHAR..LASTCHAR. Reports lock, per-error pulses and saturating counters.
//  Sits opposite chargen, or opposite the FIFO fed by chargen, in board test
//  loops and benches.
// PARAMETERS
//  FIRSTCHAR  8'h61 ("a")  first character of the cycle
//  LASTCHAR   8'h63 ("c")  last character of the cycle; must be >= FIRSTCHAR
//  CNT_W      16           width of rx_cnt and err_cnt
//  PACE       0            ready_n goes high for 1 cycle after every PACE accepts; 0 = never
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      synchronous reset, active-high
//  en       in   1      enable; low = idle, ready_n held high
//  port     in   8      received character
//  valid_n  in   1      active-low; port holds valid data
//  ready_n  out  1      active-low; sink accepts this cycle
//  locked   out  1      high while the sequence is being tracked
//  err      out  1      1-cycle pulse per sequence error
//  rx_cnt   out  CNT_W  accepted bytes, wraps modulo 2^CNT_W
//  err_cnt  out  CNT_W  sequence errors, saturates at all-ones
//  last_rx  out  8      last accepted byte
// BEHAVIOUR
//  - Reset and clock: one clock clk; reset rst is synchronous and active-high.
//  - Reset values: ready_n=1, locked=0, err=0, rx_cnt=0, err_cnt=0, last_rx=0,
//    state=IDLE, expected=FIRSTCHAR. rst overrides every other input in the same edge.
//  - Handshake: a transfer ("accept") happens on a rising edge where
//    ready_n==0 && valid_n==0. port is sampled only on an accept.
//    ready_n is registered; valid_n and port are never combinationally fed back.
//  - Every accept: rx_cnt++, last_rx<=port.
//  - FSM:
//    IDLE: ready_n=1. en=1 -> HUNT.
//    HUNT: ready_n=0 (subject to pacing).
//      accept with port==FIRSTCHAR -> LOCK, expected<=next(FIRSTCHAR).
//      Any other byte is discarded; no error.
//    LOCK: locked=1.
//      accept with port==expected -> expected<=next(expected).
//      Mismatch -> err pulses the next cycle, err_cnt++ (saturating).
//        Mismatched byte ==FIRSTCHAR -> stay in LOCK, expected<=next(FIRSTCHAR).
//        Otherwise -> HUNT, locked=0.
//    Any state, en=0 -> IDLE next edge. Lock is dropped; counters hold.
//      An accept already qualified on that edge is still counted and checked.
//  - next(c) = (c==LASTCHAR) ? FIRSTCHAR : c+1. With FIRSTCHAR==LASTCHAR every
//    byte must be FIRSTCHAR. Bytes outside the range always mismatch in LOCK.
//  - Latency: locked, err and the counters update on the edge after the accept
//    (registered outputs).
//  - Pacing (PACE>0): a pacing counter counts accepts. When it reaches PACE,
//    ready_n=1 for exactly one cycle and the counter clears. The counter clears
//    on reset and in IDLE.
//  - valid_n high: no accept, no state change; the pacing counter holds.
//  - Counter edges: rx_cnt wraps to 0 past all-ones. err_cnt sticks at all-ones.
// STRUCTURE
//  - Shared package (common include): FSM state encoding (IDLE/HUNT/LOCK), the
//    character constants, and the nT/nF active-low literals. These are shared
//    with chargen and its bench.
//  - One sub-module: chargen_sink_pacer. Inputs: clk, rst, clr, accept.
//    Output: hold, which forces ready_n high. Parameter PACE.
//  - All other logic (FSM, expected register, counters) sits in the top module.
// TESTING
//  1. Reset: rst=1 for 1 cycle -> ready_n=1, locked=0, rx_cnt=0, err_cnt=0.
//     en=1 -> ready_n=0 one cycle later.
//  2. Clean stream a,b,c,a,b,c with valid_n=0 -> locked=1 after the first "a",
//     err never pulses, rx_cnt=6, err_cnt=0, last_rx="c".
//  3. Hunt: stream c,b,a,b -> no err, locked rises after "a", rx_cnt=4.
//  4. Error: a,b,a,b,c -> err pulses once, on the cycle after the second "a".
//     err_cnt=1, locked stays 1, following b,c accepted cleanly.
//     a,b,x -> err, locked=0, state HUNT.
//  5. Stall/enable: valid_n=1 for 3 cycles mid-stream -> counters frozen.
//     en=0 -> ready_n=1 next cycle, locked=0, rx_cnt held.
//  6. PACE=2, continuous valid: ready_n pattern 0,0,1,0,0,1,...
//     After 6 cycles rx_cnt=4. With CNT_W=2, 5 forced errors -> err_cnt=3.

Source files
------------

// File: rtl/chargen_sink_pkg.sv
// ============================================================================
// chargen_sink_pkg : state encoding, character constants and active-low
//                    literals shared by chargen, chargen_sink and their benches
// Revision: 1.0
// ============================================================================
`default_nettype none

package chargen_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [7:0] CHAR_FIRST = 8'h61;
  localparam logic [7:0] CHAR_LAST  = 8'h63;

  // Active-low handshake literals: asserted / deasserted
  localparam logic nT = 1'b0;
  localparam logic nF = 1'b1;

  function automatic logic [7:0] next_char(input logic [7:0] c,
                                           input logic [7:0] first,
                                           input logic [7:0] last);
    return (c == last) ? first : c + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chargen_sink_pacer.sv
// ============================================================================
// chargen_sink_pacer : counts accepts and raises hold on the accept that
//                      completes a group of PACE, throttling the sink
// Revision: 1.0
// ============================================================================
`default_nettype none

module chargen_sink_pacer #(
  parameter int PACE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic accept,
  output logic hold
);

  generate
    if (PACE > 0) begin : g_pace
      localparam int W = $clog2(PACE + 1);
      localparam logic [W-1:0] LIMIT = W'(PACE - 1);

      logic [W-1:0] cnt;

      // hold is combinational so the registered ready_n rises on the very
      // edge that takes the PACE-th byte
      assign hold = accept && (cnt == LIMIT);

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          cnt <= '0;
        end else if (accept) begin
          cnt <= hold ? '0 : cnt + W'(1);
        end
      end
    end else begin : g_no_pace
      logic unused_pacer;
      assign unused_pacer = &{1'b0, clk, rst, clr, accept};
      assign hold = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/chargen_sink.sv
// ============================================================================
// chargen_sink : accepts a byte stream over an active-low handshake and checks
//                it follows the cyclic FIRSTCHAR..LASTCHAR sequence
// Revision: 1.0
// ============================================================================
`default_nettype none

module chargen_sink
  import chargen_sink_pkg::*;
#(
  parameter logic [7:0] FIRSTCHAR = CHAR_FIRST,
  parameter logic [7:0] LASTCHAR  = CHAR_LAST,
  parameter int         CNT_W     = 16,
  parameter int         PACE      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       port,
  input  logic             valid_n,
  output logic             ready_n,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       last_rx
);

  state_t     state;
  state_t     state_nx;
  logic [7:0] expected;
  logic [7:0] expected_nx;
  logic       accept;
  logic       mismatch;
  logic       hold;

  assign accept = (ready_n == nT) && (valid_n == nT);

  chargen_sink_pacer #(
    .PACE (PACE)
  ) u_pacer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_IDLE),
    .accept (accept),
    .hold   (hold)
  );

  always_comb begin
    state_nx    = state;
    expected_nx = expected;
    mismatch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nx = ST_HUNT;
      end
      ST_HUNT: begin
        if (accept && (port == FIRSTCHAR)) begin
          state_nx    = ST_LOCK;
          expected_nx = next_char(FIRSTCHAR, FIRSTCHAR, LASTCHAR);
        end
      end
      ST_LOCK: begin
        if (accept) begin
          if (port == expected) begin
            expected_nx = next_char(expected, FIRSTCHAR, LASTCHAR);
          end else begin
            mismatch = 1'b1;
            // A stray FIRSTCHAR restarts the cycle without losing lock
            if (port == FIRSTCHAR) begin
              expected_nx = next_char(FIRSTCHAR, FIRSTCHAR, LASTCHAR);
            end else begin
              state_nx    = ST_HUNT;
              expected_nx = FIRSTCHAR;
            end
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (!en) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      expected <= FIRSTCHAR;
      ready_n  <= nF;
      locked   <= 1'b0;
      err      <= 1'b0;
      rx_cnt   <= '0;
      err_cnt  <= '0;
      last_rx  <= 8'h00;
    end else begin
      state    <= state_nx;
      expected <= expected_nx;
      ready_n  <= ((state_nx == ST_IDLE) || hold) ? nF : nT;
      locked   <= (state_nx == ST_LOCK);
      err      <= mismatch;
      if (accept) begin
        rx_cnt  <= rx_cnt + CNT_W'(1);
        last_rx <= port;
      end
      if (mismatch && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chargen_sink.sv
// ============================================================================
// tb_chargen_sink : two sinks (unpaced 16-bit, paced 2-bit counters) driven
//                   by one stimulus stream and scored against a cycle model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_chargen_sink;

  localparam int FIRST = 8'h61;
  localparam int LAST  = 8'h63;
  localparam int M_IDLE = 0;
  localparam int M_HUNT = 1;
  localparam int M_LOCK = 2;

  typedef struct {
    int ready_n;
    int locked;
    int err;
    int rx;
    int errc;
    int last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        valid_n;
  logic [7:0]  port;

  logic        ready_n0, locked0, err0;
  logic [15:0] rx_cnt0, err_cnt0;
  logic [7:0]  last_rx0;
  logic        ready_n1, locked1, err1;
  logic [1:0]  rx_cnt1, err_cnt1;
  logic [7:0]  last_rx1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_mode[2];
  int m_exp[2];
  int m_pc[2];
  int m_rx[2];
  int m_errc[2];
  int m_last[2];
  int m_rdy_n[2];
  int m_err[2];

  chargen_sink u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .port    (port),
    .valid_n (valid_n),
    .ready_n (ready_n0),
    .locked  (locked0),
    .err     (err0),
    .rx_cnt  (rx_cnt0),
    .err_cnt (err_cnt0),
    .last_rx (last_rx0)
  );

  chargen_sink #(
    .CNT_W (2),
    .PACE  (2)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .port    (port),
    .valid_n (valid_n),
    .ready_n (ready_n1),
    .locked  (locked1),
    .err     (err1),
    .rx_cnt  (rx_cnt1),
    .err_cnt (err_cnt1),
    .last_rx (last_rx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pace_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int cmod_of(input int d);
    return (d == 0) ? 65536 : 4;
  endfunction

  function automatic int nxt(input int c);
    return (c == LAST) ? FIRST : c + 1;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input int d, input logic r, input logic e,
                            input logic vn, input logic [7:0] p);
    bit acc;
    bit hold;
    int old;
    int pv;
    pv = int'(p);
    if (r) begin
      m_mode[d] = M_IDLE; m_exp[d] = FIRST; m_pc[d] = 0; m_rx[d] = 0;
      m_errc[d] = 0; m_last[d] = 0; m_rdy_n[d] = 1; m_err[d] = 0;
      return;
    end
    acc = (m_rdy_n[d] == 0) && !vn;
    old = m_mode[d];
    hold = 1'b0;
    m_err[d] = 0;
    if (acc) begin
      m_rx[d] = (m_rx[d] + 1) % cmod_of(d);
      m_last[d] = pv;
      m_pc[d]++;
      if (old == M_HUNT && pv == FIRST) begin
        m_mode[d] = M_LOCK;
        m_exp[d] = nxt(FIRST);
      end else if (old == M_LOCK) begin
        if (pv == m_exp[d]) begin
          m_exp[d] = nxt(m_exp[d]);
        end else begin
          m_err[d] = 1;
          if (m_errc[d] < cmod_of(d) - 1) m_errc[d]++;
          if (pv == FIRST) m_exp[d] = nxt(FIRST);
          else m_mode[d] = M_HUNT;
        end
      end
      if (pace_of(d) > 0 && m_pc[d] == pace_of(d)) begin
        hold = 1'b1;
        m_pc[d] = 0;
      end
    end
    if (old == M_IDLE) begin
      m_pc[d] = 0;
      if (e) m_mode[d] = M_HUNT;
    end
    if (!e) m_mode[d] = M_IDLE;
    m_rdy_n[d] = (m_mode[d] == M_IDLE || hold) ? 1 : 0;
  endtask

  function automatic exp_t snap(input int d);
    exp_t s;
    s.ready_n = m_rdy_n[d];
    s.locked  = (m_mode[d] == M_LOCK) ? 1 : 0;
    s.err     = m_err[d];
    s.rx      = m_rx[d];
    s.errc    = m_errc[d];
    s.last    = m_last[d];
    return s;
  endfunction

  task automatic step(input logic r, input logic e, input logic vn,
                      input logic [7:0] p);
    rst = r; en = e; valid_n = vn; port = p;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d, r, e, vn, p);
    q0.push_back(snap(0));
    q1.push_back(snap(1));
    #1;
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, 1'b0, s[i]);
  endtask

  // Scoreboard monitor: every expected snapshot is compared half a cycle later
  always @(negedge clk) begin
    exp_t e0;
    exp_t e1;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      chk("dut0.ready_n", int'(ready_n0), e0.ready_n);
      chk("dut0.locked",  int'(locked0),  e0.locked);
      chk("dut0.err",     int'(err0),     e0.err);
      chk("dut0.rx_cnt",  int'(rx_cnt0),  e0.rx);
      chk("dut0.err_cnt", int'(err_cnt0), e0.errc);
      chk("dut0.last_rx", int'(last_rx0), e0.last);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("dut1.ready_n", int'(ready_n1), e1.ready_n);
      chk("dut1.locked",  int'(locked1),  e1.locked);
      chk("dut1.err",     int'(err1),     e1.err);
      chk("dut1.rx_cnt",  int'(rx_cnt1),  e1.rx);
      chk("dut1.err_cnt", int'(err_cnt1), e1.errc);
      chk("dut1.last_rx", int'(last_rx1), e1.last);
    end
  end

  initial begin
    logic [7:0] pch;
    int         sel;
    rst = 1'b1; en = 1'b0; valid_n = 1'b1; port = 8'h00;

    // Reset then enable
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("reset.ready_n", int'(ready_n0), 1);
    chk("reset.rx_cnt",  int'(rx_cnt0),  0);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("enable.ready_n", int'(ready_n0), 0);

    // Clean stream
    feed("abcabc");
    chk("clean.rx_cnt",  int'(rx_cnt0),  6);
    chk("clean.err_cnt", int'(err_cnt0), 0);
    chk("clean.last_rx", int'(last_rx0), 8'h63);
    chk("clean.locked",  int'(locked0),  1);

    // Hunt
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    feed("cbab");
    chk("hunt.rx_cnt", int'(rx_cnt0), 4);
    chk("hunt.locked", int'(locked0), 1);

    // Errors: resync on FIRSTCHAR, then loss of lock
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    feed("ababc");
    chk("resync.err_cnt", int'(err_cnt0), 1);
    chk("resync.locked",  int'(locked0),  1);
    feed("abx");
    chk("loss.err_cnt", int'(err_cnt0), 2);
    chk("loss.locked",  int'(locked0),  0);

    // Stall then disable
    feed("a");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'h62);
    chk("stall.rx_cnt", int'(rx_cnt0), 9);
    step(1'b0, 1'b0, 1'b1, 8'h62);
    chk("disable.ready_n", int'(ready_n0), 1);
    chk("disable.locked",  int'(locked0),  0);
    chk("disable.rx_cnt",  int'(rx_cnt0),  9);

    // Continuous FIRSTCHAR: paced sink takes 8 of 12, saturates its 2-bit err_cnt
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    feed("aaaaaaaaaaaa");
    chk("sat.err_cnt0", int'(err_cnt0), 11);
    chk("sat.err_cnt1", int'(err_cnt1), 3);
    chk("pace.rx_cnt1", int'(rx_cnt1), 0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       pch = 8'(m_exp[0]);
      else if (sel < 8)  pch = 8'(FIRST + int'($urandom_range(0, 2)));
      else if (sel == 8) pch = 8'h64;
      else               pch = 8'($urandom_range(0, 255));
      step($urandom_range(0, 499) == 0, $urandom_range(0, 49) != 0,
           $urandom_range(0, 3) == 0, pch);
    end

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
